mips_muldiv_unit: RTL

MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

---
 rtl/mips_muldiv_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative unsigned multiply/divide unit for a MIPS-style pipeline.
//   Multiply is radix-2 shift-add and divide is restoring division; both
//   retire one bit per RUN cycle, so a result takes WIDTH cycles after the
//   accept edge.  A divide by zero takes a single RUN cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     request valid
//   in_ready     unit idle and able to accept a request
//   op           00 MUL (low), 01 MULHU (high), 10 DIVU (quotient), 11 REMU (remainder)
//   a, b         operands (multiplicand/dividend, multiplier/divisor)
//   flush        synchronous abort of any in-flight operation
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   result       selected result, zero while out_valid is low
//   div_by_zero  DIVU/REMU with b == 0, zero while out_valid is low
//   busy         unit is in RUN or DONE (pipeline stall)
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    // hi_q:lo_q is the shared 2*WIDTH accumulator.  Multiply: product, with
    // the not-yet-consumed multiplier bits in lo_q.  Divide: partial
    // remainder in hi_q, dividend bits shifting out / quotient bits
    // shifting into lo_q.
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;

    logic             accept;
    logic             last_iter;
    logic             dz_now;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    // One shift-add step: add the multiplicand to the high half when the
    // current multiplier bit is set, then shift the whole accumulator right
    // (the add carry becomes the new top bit).
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] mcand
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {sum, lo[WIDTH-1:1]};
    endfunction

    // One restoring-division step.  The partial remainder is always below
    // the divisor, so the shifted value is below twice the divisor and the
    // difference (when non-negative) fits in WIDTH bits.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] dvsr
    );
        logic [WIDTH:0]   shifted;
        logic [WIDTH-1:0] diff;
        shifted = {hi, lo[WIDTH-1]};
        diff    = WIDTH'(shifted - {1'b0, dvsr});
        if (shifted >= {1'b0, dvsr}) begin
            return {diff, lo[WIDTH-2:0], 1'b1};
        end
        return {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    endfunction

    assign accept    = (state_q == IDLE) && in_valid && !flush;
    assign last_iter = (cnt_q == LAST_ITER);
    assign dz_now    = op_q[1] && (b_q == '0);
    assign mul_next  = mul_step(hi_q, lo_q, a_q);
    assign div_next  = div_step(hi_q, lo_q, b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid) state_d = RUN;
                RUN:     if (dz_now || last_iter) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else if (flush) begin
            cnt_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q <= '0;
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        hi_q  <= '0;
                        // Divide shifts the dividend out of lo; multiply
                        // shifts the multiplier out of lo.
                        lo_q  <= op[1] ? a : b;
                        dbz_q <= 1'b0;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dz_now) begin
                        // lo still holds the untouched dividend here.
                        hi_q  <= lo_q;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else if (op_q[1]) begin
                        {hi_q, lo_q} <= div_next;
                    end else begin
                        {hi_q, lo_q} <= mul_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    // MUL/DIVU read the low half, MULHU/REMU the high half.
    assign result      = out_valid ? (op_q[0] ? hi_q : lo_q) : '0;
    assign div_by_zero = out_valid & dbz_q;

endmodule
